// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; aligns load data, holds it across WB stalls, forwards to WB/ID/EXE.
module mem_stage #(
    parameter int E2M_LEN = 204,
    parameter int M2W_LEN = 199
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    output logic               mem_allowin,
    input  logic               exe_to_mem_valid,
    input  logic [E2M_LEN-1:0] exe_to_mem_zip,
    input  logic [31:0]        data_sram_rdata,
    input  logic               wb_allowin,
    output logic               mem_to_wb_valid,
    output logic [M2W_LEN-1:0] mem_to_wb_zip,
    output logic [38:0]        mem_rf_zip,
    output logic               mem_ex
);
    typedef struct packed {
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
        logic [3:0]  mem_op;
        logic [31:0] pc;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] vaddr;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
    } e2m_t;
    logic        mem_valid_q, mem_valid_d;
    e2m_t        bundle_q, bundle_d;
    logic        rdata_held_q, rdata_held_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic [31:0] rdata, load_data, final_res;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        accept;
    always_comb begin
        mem_allowin     = ~mem_valid_q | wb_allowin;
        mem_to_wb_valid = mem_valid_q;
        accept          = exe_to_mem_valid & mem_allowin;
        mem_valid_d     = flush ? 1'b0 : mem_allowin ? exe_to_mem_valid : mem_valid_q;
        bundle_d        = accept ? e2m_t'(exe_to_mem_zip) : bundle_q;
        // Capture the SRAM word on the first stalled cycle; the SRAM output may change afterwards.
        rdata_held_d    = (flush | (mem_valid_q & wb_allowin)) ? 1'b0 :
                          (mem_valid_q & ~wb_allowin) ? 1'b1 : rdata_held_q;
        rdata_buf_d     = (mem_valid_q & ~wb_allowin & ~rdata_held_q) ? data_sram_rdata : rdata_buf_q;
        rdata           = rdata_held_q ? rdata_buf_q : data_sram_rdata;
        ld_byte         = bundle_q.vaddr[1:0] == 2'd0 ? rdata[7:0]   :
                          bundle_q.vaddr[1:0] == 2'd1 ? rdata[15:8]  :
                          bundle_q.vaddr[1:0] == 2'd2 ? rdata[23:16] : rdata[31:24];
        ld_half         = bundle_q.vaddr[1] ? rdata[31:16] : rdata[15:0];
        load_data       = bundle_q.mem_op == 4'd3 ? {{24{ld_byte[7]}}, ld_byte}  :
                          bundle_q.mem_op == 4'd8 ? {24'd0, ld_byte}             :
                          bundle_q.mem_op == 4'd1 ? {{16{ld_half[15]}}, ld_half} :
                          bundle_q.mem_op == 4'd9 ? {16'd0, ld_half}             : rdata;
        final_res       = (bundle_q.res_from_mem & ~bundle_q.ex_valid) ? load_data : bundle_q.result;
        mem_to_wb_zip   = {bundle_q.rf_we & ~bundle_q.ex_valid, bundle_q.rf_waddr, final_res,
                           bundle_q.pc, bundle_q.csr_read, bundle_q.csr_we, bundle_q.csr_num,
                           bundle_q.csr_wmask, bundle_q.csr_wvalue, bundle_q.vaddr,
                           bundle_q.ex_valid, bundle_q.ecode, bundle_q.esubcode, bundle_q.is_ertn};
        mem_rf_zip      = {mem_valid_q & bundle_q.csr_read, mem_valid_q & bundle_q.rf_we,
                           bundle_q.rf_waddr, final_res};
        mem_ex          = mem_valid_q & (bundle_q.ex_valid | bundle_q.is_ertn);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            rdata_held_q <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            rdata_held_q <= rdata_held_d;
        end
        bundle_q    <= bundle_d;
        rdata_buf_q <= rdata_buf_d;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed load/stall/flush/exception checks for mem_stage.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         reset, flush, mem_allowin, exe_to_mem_valid, wb_allowin, mem_to_wb_valid, mem_ex;
    logic [203:0] exe_to_mem_zip;
    logic [31:0]  data_sram_rdata;
    logic [198:0] mem_to_wb_zip;
    logic [38:0]  mem_rf_zip;
    int           checks = 0, errors = 0;
    mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .mem_allowin(mem_allowin),
        .exe_to_mem_valid(exe_to_mem_valid), .exe_to_mem_zip(exe_to_mem_zip),
        .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_zip(mem_to_wb_zip),
        .mem_rf_zip(mem_rf_zip), .mem_ex(mem_ex)
    );
    always #5 clk = ~clk;
    function automatic logic [203:0] mk(input logic res, input logic we, input logic [4:0] waddr,
                                        input logic [31:0] result, input logic [3:0] op,
                                        input logic [31:0] vaddr, input logic ex,
                                        input logic [5:0] ecode, input logic csr_read);
        return {res, we, waddr, result, op, 32'h1c00_0000, csr_read, 1'b0, 14'd0, 32'd0, 32'd0,
                vaddr, ex, ecode, 9'd0, 1'b0};
    endfunction
    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1; flush = 0; exe_to_mem_valid = 0; exe_to_mem_zip = '0;
        data_sram_rdata = '0; wb_allowin = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("rst_valid", 37'(mem_to_wb_valid), 37'd0);
        chk("rst_ex", 37'(mem_ex), 37'd0);
        chk("rst_rfbits", 37'(mem_rf_zip[38:37]), 37'd0);
        chk("rst_allowin", 37'(mem_allowin), 37'd1);
        exe_to_mem_valid = 1;
        exe_to_mem_zip = mk(1, 1, 5'd5, 32'd0, 4'd3, 32'h1003, 0, 6'd0, 0);
        tick;
        exe_to_mem_zip = mk(1, 1, 5'd5, 32'd0, 4'd8, 32'h1003, 0, 6'd0, 0);
        data_sram_rdata = 32'h80FF_1234;
        #1;
        chk("ld_b", 37'(mem_rf_zip[36:0]), {5'd5, 32'hFFFF_FF80});
        chk("ld_b_we", 37'(mem_rf_zip[37]), 37'd1);
        tick;
        exe_to_mem_zip = mk(1, 1, 5'd5, 32'd0, 4'd1, 32'h1002, 0, 6'd0, 0);
        #1;
        chk("ld_bu", 37'(mem_rf_zip[31:0]), 37'h0000_0080);
        tick;
        exe_to_mem_zip = mk(1, 1, 5'd5, 32'd0, 4'd9, 32'h1002, 0, 6'd0, 0);
        data_sram_rdata = 32'h8001_7FFF;
        #1;
        chk("ld_h", 37'(mem_rf_zip[31:0]), 37'hFFFF_8001);
        tick;
        exe_to_mem_zip = mk(1, 1, 5'd5, 32'd0, 4'd2, 32'h1000, 0, 6'd0, 0);
        #1;
        chk("ld_hu", 37'(mem_rf_zip[31:0]), 37'h0000_8001);
        tick;
        exe_to_mem_zip = mk(1, 1, 5'd9, 32'd0, 4'd2, 32'h3000, 0, 6'd0, 0);
        #1;
        chk("ld_w", 37'(mem_rf_zip[31:0]), 37'h8001_7FFF);
        tick;
        wb_allowin = 0;
        data_sram_rdata = 32'h1122_3344;
        exe_to_mem_zip = mk(0, 1, 5'd7, 32'h55, 4'd0, 32'd0, 0, 6'd0, 1);
        #1;
        chk("stall1_final", 37'(mem_rf_zip[36:0]), {5'd9, 32'h1122_3344});
        chk("stall1_allowin", 37'(mem_allowin), 37'd0);
        tick;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("stall2_final", 37'(mem_rf_zip[31:0]), 37'h1122_3344);
        chk("stall2_allowin", 37'(mem_allowin), 37'd0);
        tick;
        chk("stall3_final", 37'(mem_rf_zip[31:0]), 37'h1122_3344);
        chk("stall3_allowin", 37'(mem_allowin), 37'd0);
        wb_allowin = 1;
        #1;
        chk("hs_final", 37'(mem_rf_zip[31:0]), 37'h1122_3344);
        chk("hs_allowin", 37'(mem_allowin), 37'd1);
        tick;
        exe_to_mem_valid = 0;
        #1;
        chk("after_stall_alu", 37'(mem_rf_zip[36:0]), {5'd7, 32'h55});
        chk("after_stall_csr", 37'(mem_rf_zip[38]), 37'd1);
        exe_to_mem_valid = 1; flush = 1;
        exe_to_mem_zip = mk(0, 1, 5'd2, 32'h77, 4'd0, 32'd0, 1, 6'h09, 0);
        tick;
        flush = 0; exe_to_mem_valid = 0;
        #1;
        chk("flush_valid", 37'(mem_to_wb_valid), 37'd0);
        chk("flush_ex", 37'(mem_ex), 37'd0);
        exe_to_mem_valid = 1;
        exe_to_mem_zip = mk(1, 1, 5'd6, 32'h1001, 4'd1, 32'h1001, 1, 6'h09, 0);
        tick;
        exe_to_mem_valid = 0;
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        chk("ale_ex", 37'(mem_ex), 37'd1);
        chk("ale_wb_we", 37'(mem_to_wb_zip[198]), 37'd0);
        chk("ale_final", 37'(mem_to_wb_zip[192:161]), 37'h1001);
        chk("ale_ecode", 37'(mem_to_wb_zip[15:10]), 37'h09);
        chk("ale_rf_we_ungated", 37'(mem_rf_zip[37]), 37'd1);
        exe_to_mem_valid = 1;
        exe_to_mem_zip = mk(0, 1, 5'd3, 32'hA5A5, 4'd0, 32'd0, 0, 6'd0, 0);
        tick;
        exe_to_mem_zip = mk(1, 1, 5'd4, 32'd0, 4'd2, 32'h2000, 0, 6'd0, 0);
        #1;
        chk("b2b_alu", mem_rf_zip[37:1] >> 0 == 0 ? 37'd0 : 37'(mem_rf_zip[36:0]), {5'd3, 32'hA5A5});
        chk("b2b_alu_valid", 37'(mem_to_wb_valid), 37'd1);
        tick;
        exe_to_mem_valid = 0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("b2b_ld", 37'(mem_rf_zip[36:0]), {5'd4, 32'h1234_5678});
        chk("b2b_ld_we", 37'(mem_rf_zip[37]), 37'd1);
        tick;
        chk("drain_valid", 37'(mem_to_wb_valid), 37'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
